// File: rtl/generic_ram_be.sv
// Byte-strobed RAM with N read ports, optional registered read, selectable
// read-during-write behaviour and a post-reset clear sequencer.
module generic_ram_be #(
    parameter int    WIDTH          = 32,
    parameter int    DEPTH          = 256,
    parameter int    NREAD          = 2,
    parameter int    READ_LATENCY   = 0,
    parameter bit    READ_OLD       = 1,
    parameter string DATAFILE       = "",
    parameter bit    CLEAR_ON_RESET = 1,
    localparam int   AW             = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int   NB             = WIDTH / 8
) (
    input  logic                   clock,
    input  logic                   reset,
    output logic                   ready,
    input  logic                   write_en,
    input  logic [AW-1:0]          addr_w,
    input  logic [NB-1:0]          wstrb,
    input  logic [WIDTH-1:0]       data_i,
    input  logic [NREAD-1:0]       rd_en,
    input  logic [NREAD*AW-1:0]    addr_r,
    output logic [NREAD*WIDTH-1:0] data_o,
    output logic [NREAD-1:0]       rvalid
);

    localparam bit CLEAR_EN = (DATAFILE == "") && CLEAR_ON_RESET;

    typedef enum logic {CLEAR, RUN} state_t;

    state_t           state_q, state_d;
    logic [AW-1:0]    clear_addr_q, clear_addr_d;
    logic             ready_q;
    logic             wr_fire;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rd_word [NREAD];

    if (WIDTH % 8 != 0) begin : g_bad_width
        $error("generic_ram_be: WIDTH must be a multiple of 8");
    end
    if (NREAD < 1) begin : g_bad_nread
        $error("generic_ram_be: NREAD must be at least 1");
    end
    if (READ_LATENCY != 0 && READ_LATENCY != 1) begin : g_bad_latency
        $error("generic_ram_be: READ_LATENCY must be 0 or 1");
    end

    // ready is registered separately so it stays low during reset even when no clear runs
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= CLEAR_EN ? CLEAR : RUN;
            clear_addr_q <= '0;
            ready_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            clear_addr_q <= clear_addr_d;
            ready_q      <= (state_d == RUN);
        end
    end

    always_comb begin
        state_d      = state_q;
        clear_addr_d = clear_addr_q;
        if (state_q == CLEAR) begin
            if (32'(clear_addr_q) == DEPTH - 1) begin
                state_d      = RUN;
                clear_addr_d = '0;
            end else begin
                clear_addr_d = clear_addr_q + 1'b1;
            end
        end
    end

    assign ready   = ready_q;
    assign wr_fire = ready_q && write_en && (32'(addr_w) < DEPTH);

    always_ff @(posedge clock) begin
        if (!reset && state_q == CLEAR) begin
            mem[clear_addr_q] <= '0;
        end else if (wr_fire) begin
            for (int b = 0; b < NB; b++) begin
                if (wstrb[b]) mem[addr_w][8*b +: 8] <= data_i[8*b +: 8];
            end
        end
    end

    // Out-of-range reads give zero; forwarding only applies to writes that land
    always_comb begin
        for (int i = 0; i < NREAD; i++) begin
            rd_word[i] = '0;
            if (32'(addr_r[i*AW +: AW]) < DEPTH) begin
                rd_word[i] = mem[addr_r[i*AW +: AW]];
            end
            if (!READ_OLD && wr_fire && addr_r[i*AW +: AW] == addr_w) begin
                for (int b = 0; b < NB; b++) begin
                    if (wstrb[b]) rd_word[i][8*b +: 8] = data_i[8*b +: 8];
                end
            end
        end
    end

    if (READ_LATENCY == 0) begin : g_comb_read
        for (genvar i = 0; i < NREAD; i++) begin : g_port
            assign data_o[i*WIDTH +: WIDTH] = rd_word[i];
        end
        assign rvalid = rd_en & {NREAD{ready_q}};
    end else begin : g_reg_read
        logic [NREAD*WIDTH-1:0] data_q;
        logic [NREAD-1:0]       rvalid_q;

        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                data_q   <= '0;
                rvalid_q <= '0;
            end else begin
                for (int i = 0; i < NREAD; i++) begin
                    if (rd_en[i] && ready_q) data_q[i*WIDTH +: WIDTH] <= rd_word[i];
                end
                rvalid_q <= rd_en & {NREAD{ready_q}};
            end
        end

        assign data_o = data_q;
        assign rvalid = rvalid_q;
    end

endmodule
